// File: rtl/addsub_pkg.sv
// ============================================================================
// Module      : addsub_pkg
// Description : Shared state encoding and default sizing for serial_addsub.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int c_DEF_WIDTH = 9;
  localparam int c_DEF_DIGIT = 3;

endpackage

`default_nettype wire

// File: rtl/digit_adder.sv
// ============================================================================
// Module      : digit_adder
// Description : DIGIT-wide combinational ripple-carry slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module digit_adder #(
  parameter int DIGIT = 3
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign s[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout     = w_c[DIGIT];
  // Needed by the parent to form overflow on the final slice.
  assign c_msb_in = w_c[DIGIT-1];

endmodule

`default_nettype wire

// File: rtl/serial_addsub.sv
// ============================================================================
// Module      : serial_addsub
// Description : Digit-serial adder/subtractor, one DIGIT slice per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = c_DEF_WIDTH,
  parameter int DIGIT = c_DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int c_N  = WIDTH / DIGIT;
  localparam int c_IW = (c_N > 1) ? $clog2(c_N) : 1;
  localparam logic [c_IW-1:0] c_LAST = c_IW'(c_N - 1);

  if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_width_check
    $error("serial_addsub: WIDTH must be a positive multiple of DIGIT");
  end

  state_t           r_state;
  logic [c_IW-1:0]  r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_c;

  logic [DIGIT-1:0] w_sum;
  logic             w_cout;
  logic             w_cmsb;
  logic [WIDTH-1:0] w_acc_next;

  digit_adder #(
    .DIGIT (DIGIT)
  ) u_digit_adder (
    .a        (r_a[DIGIT-1:0]),
    .b        (r_b[DIGIT-1:0]),
    .cin      (r_c),
    .s        (w_sum),
    .cout     (w_cout),
    .c_msb_in (w_cmsb)
  );

  // Slice sums enter at the top and walk down, so after N slices the
  // accumulator holds the result LSB-aligned.
  if (DIGIT == WIDTH) begin : g_acc_full
    assign w_acc_next = w_sum;
  end else begin : g_acc_shift
    assign w_acc_next = {w_sum, r_acc[WIDTH-1:DIGIT]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_c     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      s       <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_c     <= sub ? 1'b1 : cin;
            r_acc   <= '0;
            r_idx   <= '0;
            r_state <= ST_RUN;
            busy    <= 1'b1;
          end
        end
        ST_RUN: begin
          r_a   <= r_a >> DIGIT;
          r_b   <= r_b >> DIGIT;
          r_c   <= w_cout;
          r_acc <= w_acc_next;
          r_idx <= r_idx + c_IW'(1);
          if (r_idx == c_LAST) begin
            r_state <= ST_DONE;
            s       <= w_acc_next;
            cout    <= w_cout;
            ovf     <= w_cout ^ w_cmsb;
            done    <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter WIDTH, default 9, operand and result width in bits.
REQ-002 Parameter DIGIT, default 3, bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT (elaboration error otherwise).
REQ-003 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 a  input  WIDTH  operand A, captured when start is accepted.
REQ-007 b  input  WIDTH  operand B, captured when start is accepted.
REQ-008 sub  input  1  mode, captured with the operands: 0 computes A+B+cin, 1 computes A-B.
REQ-009 cin  input  1  carry-in for add mode; ignored in subtract mode.
REQ-010 busy  output  1  high in RUN and DONE.
REQ-011 done  output  1  one-cycle pulse marking a new valid result.
REQ-012 s  output  WIDTH  full-width sum or difference, with no truncated bits.
REQ-013 cout  output  1  carry out of the MSB; in subtract mode, 1 means no borrow.
REQ-014 ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Function
REQ-015 The block SHALL implement a three-state FSM: IDLE, RUN and DONE. N is WIDTH/DIGIT.
REQ-016 IDLE with start=1 at a clock edge: the block SHALL capture a, b and sub, go to RUN and set the digit index to 0.
- In the same edge, the operand register SHALL load b, or ~b when sub=1.
- In the same edge, the carry register SHALL load cin, or 1 when sub=1.
REQ-017 Each RUN edge SHALL add one DIGIT-wide slice, LSB-first, using the registered carry.
- It SHALL store the slice sum and the new carry.
- It SHALL increment the index.
REQ-018 The edge that processes slice N-1 SHALL move the FSM to DONE and update s, cout and ovf.
- With start accepted at edge 0, done SHALL be high for exactly the cycle following edge N.
REQ-019 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-020 start asserted in RUN or DONE SHALL be ignored; it is neither queued nor allowed to disturb the operation in progress.
REQ-021 Operand inputs SHALL NOT affect an operation once it has been accepted.
REQ-022 s, cout and ovf SHALL change only on entry to DONE.
- They SHALL hold their values through IDLE until the next result completes.
- Partial sums SHALL NOT be visible on s.
REQ-023 ovf SHALL be derived from the carry into bit WIDTH-1 and the carry out of it, as captured during the final slice.
REQ-024 When DIGIT equals WIDTH, N=1 and done SHALL follow start by one cycle.

Reset
REQ-025 rst_n=0 at a clock edge SHALL force IDLE, clear the index and internal registers, and set busy=0, done=0, s=0, cout=0, ovf=0.
REQ-026 A reset during RUN or DONE SHALL abort the operation, with no done pulse afterwards.
REQ-027 A start coinciding with rst_n=0 SHALL be ignored.
REQ-028 The block SHALL accept start on the first edge after rst_n returns high.

Structure
REQ-029 State encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10) SHALL live in the shared package addsub_pkg.
- The package SHALL also hold the default WIDTH and DIGIT constants.
REQ-030 A single sub-module, digit_adder, SHALL implement the DIGIT-wide combinational ripple slice.
- digit_adder SHALL be parametrised by DIGIT.
- Its ports SHALL be a, b, cin, s, cout and c_msb_in, where c_msb_in is the carry into the slice MSB.
- It SHALL be instantiated once.
REQ-031 Operand slices SHALL be selected either by right-shifting the operand registers or by an indexed part-select; both are acceptable.
- A full-width combinational adder SHALL NOT be used.

Verification (WIDTH=9, DIGIT=3, N=3)
REQ-032 Add 0x0FF+0x001, cin=0 -> s=0x100, cout=0, ovf=1; done is high 3 cycles after the start edge and lasts 1 cycle.
REQ-033 Add 0x1FF+0x001, cin=0 -> s=0x000, cout=1, ovf=0; add 0x003+0x004, cin=1 -> s=0x008, cout=0, ovf=0.
REQ-034 Subtract 0x005-0x007 (cin=1 driven, ignored) -> s=0x1FE, cout=0, ovf=0; subtract 0x100-0x001 -> s=0x0FF, cout=1, ovf=1.
REQ-035 start re-pulsed with new operands in RUN and in DONE -> both ignored; the original result is delivered and busy drops after DONE.
REQ-036 rst_n=0 for one edge in mid-RUN -> the next cycle shows IDLE with all outputs 0 and no done pulse; a start on the following edge completes normally.
REQ-037 Back-to-back: start held high continuously -> an operation is accepted every N+2 cycles and s is stable between done pulses.
